// File: rtl/calculator_seq_core.sv
// calculator_seq_core: debounced-button calculator with add/sub/logic/accumulate, shift-add multiply and restoring divide; define CALC_REM_EN to return the divide remainder in the upper half
module calculator_seq_core #(
  parameter int WIDTH = 8,
  parameter int DB_CYCLES = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  input  logic [2:0]         func,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  output logic [2*WIDTH-1:0] cal_result,
  output logic               button_new,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q, db_q, db_d, db_dly_q;
  logic button_new_q, button_new_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d, db_cnt_inc;
  logic [RW-1:0] res_q, res_d, acc_q, acc_d, mcand_q, mcand_d, mul_nx, div_res, dz_res;
  logic [WIDTH-1:0] sh_q, sh_d, rem_q, rem_d, dvs_q, dvs_d, rem_nx, quo_nx;
  logic [WIDTH:0] trial, diff;
  logic [IW-1:0] it_q, it_d;
  logic ge, last, db_hit;
  assign db_cnt_inc = db_cnt_q + 1'b1;
  assign db_hit = db_cnt_inc == CW'(DB_CYCLES);
  assign mul_nx = sh_q[0] ? acc_q + mcand_q : acc_q;
  assign trial = {rem_q, sh_q[WIDTH-1]};
  assign diff = trial - {1'b0, dvs_q};
  // the partial remainder stays below the divisor, so a set top bit can only mean a borrow
  assign ge = ~diff[WIDTH];
  assign rem_nx = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx = {sh_q[WIDTH-2:0], ge};
  assign last = it_q == IW'(WIDTH - 1);
`ifdef CALC_REM_EN
  assign div_res = {rem_nx, quo_nx};
  assign dz_res = {num1, {WIDTH{1'b1}}};
`else
  assign div_res = {{WIDTH{1'b0}}, quo_nx};
  assign dz_res = '1;
`endif
  always_comb begin
    state_d = state_q;
    db_d = db_q;
    db_cnt_d = '0;
    button_new_d = db_q & ~db_dly_q;
    done_d = 1'b0;
    err_d = err_q;
    res_d = res_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    sh_d = sh_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    it_d = it_q;
    if (sync2_q != db_q) begin
      db_cnt_d = db_hit ? '0 : db_cnt_inc;
      db_d = db_hit ? ~db_q : db_q;
    end
    case (state_q)
      IDLE: if (button_new_q) begin
        state_d = DONE;
        done_d = 1'b1;
        err_d = 1'b0;
        it_d = '0;
        acc_d = '0;
        mcand_d = {{WIDTH{1'b0}}, num1};
        sh_d = (func == 3'b011) ? num1 : num2;
        rem_d = '0;
        dvs_d = num2;
        case (func)
          3'b000: res_d = {{WIDTH{1'b0}}, num1} + {{WIDTH{1'b0}}, num2};
          3'b001: res_d = {{WIDTH{1'b0}}, num1} - {{WIDTH{1'b0}}, num2};
          3'b010: begin
            state_d = MUL;
            done_d = 1'b0;
          end
          3'b011: begin
            state_d = (num2 == '0) ? DONE : DIV;
            done_d = num2 == '0;
            err_d = num2 == '0;
            res_d = (num2 == '0) ? dz_res : res_q;
          end
          3'b100: res_d = {{WIDTH{1'b0}}, num1 & num2};
          3'b101: res_d = {{WIDTH{1'b0}}, num1 | num2};
          3'b110: res_d = {{WIDTH{1'b0}}, num1 ^ num2};
          default: res_d = res_q + {{WIDTH{1'b0}}, num1};
        endcase
      end
      MUL: begin
        acc_d = mul_nx;
        mcand_d = mcand_q << 1;
        sh_d = sh_q >> 1;
        it_d = it_q + 1'b1;
        state_d = last ? DONE : MUL;
        done_d = last;
        res_d = last ? mul_nx : res_q;
      end
      DIV: begin
        rem_d = rem_nx;
        sh_d = quo_nx;
        it_d = it_q + 1'b1;
        state_d = last ? DONE : DIV;
        done_d = last;
        res_d = last ? div_res : res_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q <= 1'b0;
      db_dly_q <= 1'b0;
      db_cnt_q <= '0;
      button_new_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      res_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      sh_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      it_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= button;
      sync2_q <= sync1_q;
      db_q <= db_d;
      db_dly_q <= db_q;
      db_cnt_q <= db_cnt_d;
      button_new_q <= button_new_d;
      done_q <= done_d;
      err_q <= err_d;
      res_q <= res_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      sh_q <= sh_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      it_q <= it_d;
    end
  end
  assign cal_result = res_q;
  assign button_new = button_new_q;
  assign busy = (state_q == MUL) || (state_q == DIV);
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_calculator_seq_core.sv
// tb_calculator_seq_core: scoreboard bench for calculator_seq_core (WIDTH=8, DB_CYCLES=4)
module tb_calculator_seq_core;
  logic clk = 1'b0;
  logic rst, button;
  logic [2:0] func;
  logic [7:0] num1, num2;
  logic [15:0] cal_result;
  logic button_new, busy, done, err;
  typedef struct {
    logic [15:0] res;
    logic e;
    int lat;
    int bsy;
  } exp_t;
  exp_t sb[$];
  int passed = 0, total = 0, exp_bn = 0, bn_cnt = 0;
  int ncyc = 0, bn_cyc = 0, busy_run = 0;
  logic [15:0] acc_m;

  calculator_seq_core #(.WIDTH(8), .DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .button(button), .func(func), .num1(num1), .num2(num2),
    .cal_result(cal_result), .button_new(button_new), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // monitor: every done pulse pops one expectation; latency and busy time are measured from the accepted button_new
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      ncyc++;
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: done with nothing pending, cal_result 0x%h", cal_result);
        end else begin
          x = sb.pop_front();
          check("result", 32'(cal_result), 32'(x.res));
          check("err_at_done", 32'(err), 32'(x.e));
          check("done_latency", ncyc - bn_cyc, x.lat);
          check("busy_cycles", busy_run, x.bsy);
        end
      end
      if (button_new) begin
        bn_cnt++;
        if (!busy && !done) begin
          bn_cyc = ncyc;
          busy_run = 0;
        end
      end
    end
  end

  // button_new is expected 7 sampled edges after the level is applied: 2 sync + 4 debounce + 1 pulse register
  task automatic press(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] er, input logic ee, input int lat, input int bsy, input bit bounce);
    int n = 0;
    func = f;
    num1 = a;
    num2 = b;
    sb.push_back('{er, ee, lat, bsy});
    exp_bn++;
    if (bounce) for (int i = 0; i < 4; i++) begin
      button = ~i[0];
      @(negedge clk);
    end
    button = 1'b1;
    while (n < 30 && !button_new) begin
      @(negedge clk);
      n++;
    end
    check("button_new_delay", n, 7);
    @(negedge clk);
    func = ~f;
    num1 = ~a;
    num2 = ~b;
    button = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    button = 1'b0;
    func = 3'b000;
    num1 = 8'h00;
    num2 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_result", 32'(cal_result), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_button_new", 32'(button_new), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    press(3'b000, 8'hFF, 8'h01, 16'h0100, 1'b0, 1, 0, 1'b1);
    press(3'b001, 8'h05, 8'h07, 16'hFFFE, 1'b0, 1, 0, 1'b0);
    // multiply with a second press whose button_new lands while busy
    func = 3'b010;
    num1 = 8'hFF;
    num2 = 8'hFF;
    sb.push_back('{16'hFE01, 1'b0, 9, 8});
    exp_bn += 2;
    button = 1'b1;
    repeat (4) @(negedge clk);
    button = 1'b0;
    repeat (4) @(negedge clk);
    button = 1'b1;
    func = 3'b000;
    num1 = 8'h00;
    num2 = 8'h00;
    repeat (4) @(negedge clk);
    button = 1'b0;
    repeat (20) @(negedge clk);
    check("mul_hold", 32'(cal_result), 32'h0000FE01);
    check("bn_count_overlap", bn_cnt, exp_bn);
`ifdef CALC_REM_EN
    press(3'b011, 8'd200, 8'd7, 16'h041C, 1'b0, 9, 8, 1'b0);
    press(3'b011, 8'h12, 8'h00, 16'h12FF, 1'b1, 1, 0, 1'b0);
`else
    press(3'b011, 8'd200, 8'd7, 16'h001C, 1'b0, 9, 8, 1'b0);
    press(3'b011, 8'h12, 8'h00, 16'hFFFF, 1'b1, 1, 0, 1'b0);
`endif
    check("err_sticky", 32'(err), 1);
    press(3'b100, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1, 0, 1'b0);
    check("err_cleared", 32'(err), 0);
    press(3'b101, 8'hF0, 8'h0C, 16'h00FC, 1'b0, 1, 0, 1'b0);
    press(3'b110, 8'hFF, 8'h0F, 16'h00F0, 1'b0, 1, 0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    acc_m = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      acc_m = acc_m + 16'h0080;
      press(3'b111, 8'h80, 8'h00, acc_m, 1'b0, 1, 0, 1'b0);
    end
    check("acc_five", 32'(cal_result), 32'h00000280);
    for (int i = 0; i < 511; i++) begin
      acc_m = acc_m + 16'h0080;
      press(3'b111, 8'h80, 8'h00, acc_m, 1'b0, 1, 0, 1'b0);
    end
    check("acc_wrap", 32'(cal_result), 32'h00000200);
    // reset after four multiply iterations must abort without a done pulse
    func = 3'b010;
    num1 = 8'h03;
    num2 = 8'h05;
    exp_bn++;
    button = 1'b1;
    n = 0;
    while (n < 30 && !button_new) begin
      @(negedge clk);
      n++;
    end
    check("abort_bn_delay", n, 7);
    @(negedge clk);
    button = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_mid_mul", 32'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_result", 32'(cal_result), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_err", 32'(err), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    press(3'b010, 8'h03, 8'h05, 16'h000F, 1'b0, 9, 8, 1'b0);
    repeat (20) @(negedge clk);
    check("queue_empty", 32'(sb.size()), 0);
    check("button_new_count", bn_cnt, exp_bn);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
